// File: rtl/video_hdmiport_pal.sv
// HDMI output port for 4-bit RGBI video with a programmable 16-entry palette.
// Two-stage pixel pipeline (input capture, palette lookup), DE delay line,
// and a staged palette write that commits only when it cannot tear the image.
//
// Palette write FSM
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no write staged, pal_wr_ready_o = 1
//   ST_PEND | write staged, waiting for its commit slot (vsync or next cycle)
module video_hdmiport_pal #(
    parameter int COLOR_BITS = 8,
    parameter int DE_SKEW    = 1,
    parameter int HS_POL     = 1,
    parameter int VS_POL     = 1,
    parameter int BLANK_ZERO = 1,
    parameter int COMMIT_VS  = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [3:0]              video_i,
    input  logic                    display_enable_i,
    input  logic                    hsync_i,
    input  logic                    vsync_i,
    input  logic                    pal_wr_valid_i,
    output logic                    pal_wr_ready_o,
    input  logic [3:0]              pal_wr_addr_i,
    input  logic [3*COLOR_BITS-1:0] pal_wr_data_i,
    output logic [COLOR_BITS-1:0]   hdmi_red_o,
    output logic [COLOR_BITS-1:0]   hdmi_grn_o,
    output logic [COLOR_BITS-1:0]   hdmi_blu_o,
    output logic                    hdmi_hs_o,
    output logic                    hdmi_vs_o,
    output logic                    hdmi_de_o,
    output logic                    hdmi_clk_o
);

    localparam int CW    = 3 * COLOR_BITS;
    localparam int F_LVL = (1 << COLOR_BITS) - 1;
    localparam int H_LVL = (2 * F_LVL) / 3;
    localparam int L_LVL = F_LVL / 3;
    // Inactive output sync level; XOR with the active-high input gives the output polarity.
    localparam logic HS_INV = (HS_POL == 0);
    localparam logic VS_INV = (VS_POL == 0);

    typedef enum logic {ST_IDLE, ST_PEND} state_t;

    // Standard CGA colour for an index, including the brown special case at index 6.
    function automatic logic [CW-1:0] default_entry(input logic [3:0] idx);
        logic [COLOR_BITS-1:0] lo;
        logic [COLOR_BITS-1:0] r;
        logic [COLOR_BITS-1:0] g;
        logic [COLOR_BITS-1:0] b;
        lo = idx[3] ? COLOR_BITS'(L_LVL) : '0;
        r  = (idx[2] ? COLOR_BITS'(H_LVL) : '0) + lo;
        g  = (idx[1] ? COLOR_BITS'(H_LVL) : '0) + lo;
        b  = (idx[0] ? COLOR_BITS'(H_LVL) : '0) + lo;
        if (idx == 4'd6) begin
            g = COLOR_BITS'(L_LVL);
        end
        return {r, g, b};
    endfunction

    logic [1:0]          rst_sync_q;
    logic                rst_n;
    logic [3:0]          video_q;
    logic                de_s1_q;
    logic                hs_s1_q;
    logic                vs_s1_q;
    logic [CW-1:0]       rgb_q;
    logic                hs_q;
    logic                vs_q;
    logic [DE_SKEW:0]    de_sr_q;
    logic [CW-1:0]       pal_q [16];
    state_t              state_q;
    state_t              state_d;
    logic                wr_accept;
    logic                wr_commit;
    logic [3:0]          stage_addr_q;
    logic [CW-1:0]       stage_data_q;
    logic                blank;

    // Reset synchronizer: assertion is immediate, release is aligned to clk_i.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Stage 1: capture pixel, enable and syncs unconditionally.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            video_q <= '0;
            de_s1_q <= 1'b0;
            hs_s1_q <= 1'b0;
            vs_s1_q <= 1'b0;
        end else begin
            video_q <= video_i;
            de_s1_q <= display_enable_i;
            hs_s1_q <= hsync_i;
            vs_s1_q <= vsync_i;
        end
    end

    // Stage 2: palette lookup and polarity-adjusted syncs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs_q  <= HS_INV;
            vs_q  <= VS_INV;
        end else begin
            rgb_q <= pal_q[video_q];
            hs_q  <= hs_s1_q ^ HS_INV;
            vs_q  <= vs_s1_q ^ VS_INV;
        end
    end

    // DE delay line: stage-2 alignment plus DE_SKEW extra cycles.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            de_sr_q <= '0;
        end else begin
            de_sr_q[0] <= de_s1_q;
            for (int i = 1; i <= DE_SKEW; i++) begin
                de_sr_q[i] <= de_sr_q[i-1];
            end
        end
    end

    // Palette storage; the stage-2 read in a commit cycle still sees the old entry.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                pal_q[i] <= default_entry(4'(i));
            end
        end else if (wr_commit) begin
            pal_q[stage_addr_q] <= stage_data_q;
        end
    end

    // Staging register for the accepted write.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stage_addr_q <= '0;
            stage_data_q <= '0;
        end else if (wr_accept) begin
            stage_addr_q <= pal_wr_addr_i;
            stage_data_q <= pal_wr_data_i;
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write FSM next state: accept only in IDLE, so a write never commits in its accept cycle.
    always_comb begin
        state_d        = state_q;
        pal_wr_ready_o = 1'b0;
        wr_accept      = 1'b0;
        wr_commit      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pal_wr_ready_o = 1'b1;
                wr_accept      = pal_wr_valid_i;
                if (pal_wr_valid_i) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if ((COMMIT_VS == 0) || vs_s1_q) begin
                    wr_commit = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output stage: blank RGB whenever the delayed DE is low.
    assign hdmi_de_o  = de_sr_q[DE_SKEW];
    assign blank      = (BLANK_ZERO != 0) && !hdmi_de_o;
    assign hdmi_red_o = blank ? '0 : rgb_q[CW-1 -: COLOR_BITS];
    assign hdmi_grn_o = blank ? '0 : rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
    assign hdmi_blu_o = blank ? '0 : rgb_q[COLOR_BITS-1:0];
    assign hdmi_hs_o  = hs_q;
    assign hdmi_vs_o  = vs_q;
    assign hdmi_clk_o = clk_i;

endmodule

// File: tb/tb_video_hdmiport_pal.sv
// Bench for video_hdmiport_pal: directed scenarios followed by random traffic,
// compared every cycle against a cycle-history model of the port.
module tb_video_hdmiport_pal;

    localparam int CB   = 8;
    localparam int SKEW = 1;
    localparam int HSP  = 0;
    localparam int VSP  = 1;
    localparam int HMAX = 2048;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [3:0]    video;
    logic          de_in, hs_in, vs_in;
    logic          wr_valid;
    logic          wr_ready;
    logic [3:0]    wr_addr;
    logic [23:0]   wr_data;
    logic [7:0]    red, grn, blu;
    logic          hs_out, vs_out, de_out, clk_out;

    int checks   = 0;
    int failures = 0;

    // Reference state: palette contents, one pending write, input history per cycle.
    logic [23:0] m_pal [16];
    logic        m_pend;
    logic [3:0]  m_sa;
    logic [23:0] m_sd;
    logic [3:0]  h_vid [HMAX];
    logic        h_de  [HMAX];
    logic        h_hs  [HMAX];
    logic        h_vs  [HMAX];
    int          n        = 0;
    int          hbase    = 0;
    int          sync_cnt = 0;

    always #5 clk = ~clk;

    video_hdmiport_pal #(
        .COLOR_BITS(CB), .DE_SKEW(SKEW), .HS_POL(HSP), .VS_POL(VSP),
        .BLANK_ZERO(1), .COMMIT_VS(1)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .video_i(video),
        .display_enable_i(de_in), .hsync_i(hs_in), .vsync_i(vs_in),
        .pal_wr_valid_i(wr_valid), .pal_wr_ready_o(wr_ready),
        .pal_wr_addr_i(wr_addr), .pal_wr_data_i(wr_data),
        .hdmi_red_o(red), .hdmi_grn_o(grn), .hdmi_blu_o(blu),
        .hdmi_hs_o(hs_out), .hdmi_vs_o(vs_out), .hdmi_de_o(de_out),
        .hdmi_clk_o(clk_out)
    );

    function automatic logic [23:0] spec_default(input int idx);
        int f, hi, lo, ion, r, g, b;
        f   = 255;
        hi  = (2 * f) / 3;
        lo  = f / 3;
        ion = (idx >> 3) & 1;
        r   = ((idx >> 2) & 1) * hi + ion * lo;
        g   = ((idx >> 1) & 1) * hi + ion * lo;
        b   = (idx & 1) * hi + ion * lo;
        if (idx == 6) g = lo;
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    function automatic logic [3:0] hv(input int i);
        return (i < hbase || i < 0) ? 4'd0 : h_vid[i];
    endfunction
    function automatic logic hd(input int i);
        return (i < hbase || i < 0) ? 1'b0 : h_de[i];
    endfunction
    function automatic logic hh(input int i);
        return (i < hbase || i < 0) ? 1'b0 : h_hs[i];
    endfunction
    function automatic logic hs_v(input int i);
        return (i < hbase || i < 0) ? 1'b0 : h_vs[i];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pal[i] = spec_default(i);
        m_pend   = 1'b0;
        hbase    = n;
        sync_cnt = 2;
    endtask

    // One clock: drive at negedge, check ready, clock, check outputs at next negedge.
    task automatic step(input logic [3:0] v, input logic de, input logic hs, input logic vs,
                        input logic wv, input logic [3:0] wa, input logic [23:0] wd);
        logic        commit, accept, de_e, hs_e, vs_e;
        logic [23:0] rgb_e;
        if (n >= HMAX) begin
            $display("FAIL hist_overflow n=%0d limit=%0d", n, HMAX);
            $fatal(1, "history overflow");
        end
        video = v; de_in = de; hs_in = hs; vs_in = vs;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        #1;
        chk("ready", 32'(wr_ready), 32'(!m_pend));
        commit = (sync_cnt == 0) && m_pend && hs_v(n - 1);
        accept = (sync_cnt == 0) && !m_pend && wv;
        de_e   = hd(n - 1 - SKEW);
        rgb_e  = de_e ? m_pal[hv(n - 1)] : 24'h0;
        hs_e   = hh(n - 1) ^ (HSP == 0);
        vs_e   = hs_v(n - 1) ^ (VSP == 0);
        h_vid[n] = (sync_cnt > 0) ? 4'd0 : v;
        h_de[n]  = (sync_cnt > 0) ? 1'b0 : de;
        h_hs[n]  = (sync_cnt > 0) ? 1'b0 : hs;
        h_vs[n]  = (sync_cnt > 0) ? 1'b0 : vs;
        @(posedge clk);
        if (commit) begin
            m_pal[m_sa] = m_sd;
            m_pend = 1'b0;
        end
        if (accept) begin
            m_sa = wa;
            m_sd = wd;
            m_pend = 1'b1;
        end
        if (sync_cnt > 0) sync_cnt--;
        @(negedge clk);
        chk("rgb", 32'({red, grn, blu}), 32'(rgb_e));
        chk("de", 32'(de_out), 32'(de_e));
        chk("hs", 32'(hs_out), 32'(hs_e));
        chk("vs", 32'(vs_out), 32'(vs_e));
        n++;
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_rgb"}, 32'({red, grn, blu}), 32'h0);
        chk({tag, "_de"}, 32'(de_out), 32'h0);
        chk({tag, "_hs"}, 32'(hs_out), 32'(HSP == 0));
        chk({tag, "_vs"}, 32'(vs_out), 32'(VSP == 0));
        chk({tag, "_ready"}, 32'(wr_ready), 32'h1);
    endtask

    // Asynchronous assertion mid-cycle, release at a negedge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        reset_values("rst_async");
        video = 4'hF; de_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1; wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_values("rst_hold");
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        logic vs_r;
        reset_n = 1'b0;
        video = '0; de_in = 0; hs_in = 0; vs_in = 0;
        wr_valid = 0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        reset_values("rst_init");
        #2;
        chk("clk_pass_hi", 32'(clk_out), 32'(clk));
        @(negedge clk);
        chk("clk_pass_lo", 32'(clk_out), 32'(clk));
        model_reset();
        reset_n = 1'b1;

        // Default palette walk.
        for (int i = 0; i < 16; i++) step(4'(i), 1, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);

        // DE burst of four with skew.
        repeat (4) step(5, 1, 0, 0, 0, 0, 0);
        repeat (4) step(5, 0, 0, 0, 0, 0, 0);

        // hsync pulse, active-low output.
        repeat (3) step(0, 0, 1, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0);

        // Write index 6 outside vsync; commits only after vsync rises.
        repeat (3) step(6, 1, 0, 0, 0, 0, 0);
        chk("t4_old", 32'({red, grn, blu}), 32'hAA5500);
        step(6, 1, 0, 0, 1, 6, 24'h123456);
        repeat (4) step(6, 1, 0, 0, 0, 0, 0);
        chk("t4_hold", 32'({red, grn, blu}), 32'hAA5500);
        repeat (4) step(6, 1, 0, 1, 0, 0, 0);
        repeat (3) step(6, 1, 0, 0, 0, 0, 0);
        chk("t4_new", 32'({red, grn, blu}), 32'h123456);

        // Back-to-back writes to one index during vsync; last wins.
        step(3, 1, 0, 1, 1, 3, 24'hA1B2C3);
        step(3, 1, 0, 1, 1, 3, 24'hD4E5F6);
        step(3, 1, 0, 1, 1, 3, 24'hD4E5F6);
        step(3, 1, 0, 1, 0, 0, 0);
        repeat (3) step(3, 1, 0, 0, 0, 0, 0);
        chk("t5_last", 32'({red, grn, blu}), 32'hD4E5F6);

        // Reset while a write is pending.
        step(1, 1, 0, 0, 1, 6, 24'h777777);
        step(1, 1, 0, 0, 0, 0, 0);
        async_reset();
        for (int i = 0; i < 16; i++) step(4'(i), 1, 0, 0, 0, 0, 0);
        repeat (3) step(6, 1, 0, 0, 0, 0, 0);
        chk("t6_default6", 32'({red, grn, blu}), 32'hAA5500);

        // Random traffic.
        vs_r = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) vs_r = ~vs_r;
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), vs_r,
                 ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)), 24'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
